// File: rtl/alu_8bit.sv
// 8-bit, 16-opcode ALU with a single registered output stage.
// F updates every clk edge with one cycle of latency; rst clears F to zero.
module alu_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] instruction,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] F
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_NOT  = 4'b0110,
        OP_XNOR = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_ROL  = 4'b1011,
        OP_ROR  = 4'b1100,
        OP_LTU  = 4'b1101,
        OP_EQ   = 4'b1110,
        OP_LTS  = 4'b1111
    } op_e;

    logic [2:0]  sh;
    logic [15:0] rol_w;
    logic [15:0] ror_w;
    logic [7:0]  res;

    // Rotates come from shifting a doubled copy of A and picking one half.
    assign sh    = B[2:0];
    assign rol_w = {A, A} << sh;
    assign ror_w = {A, A} >> sh;

    always_comb begin
        res = 8'h00;
        case (op_e'(instruction))
            OP_ADD:  res = A + B;
            OP_SUB:  res = A - B;
            OP_MUL:  res = A * B;
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_NOT:  res = ~A;
            OP_XNOR: res = ~(A ^ B);
            OP_SLL:  res = A << sh;
            OP_SRL:  res = A >> sh;
            OP_SRA:  res = $unsigned($signed(A) >>> sh);
            OP_ROL:  res = rol_w[15:8];
            OP_ROR:  res = ror_w[7:0];
            OP_LTU:  res = {7'b0, (A < B)};
            OP_EQ:   res = {7'b0, (A == B)};
            OP_LTS:  res = {7'b0, ($signed(A) < $signed(B))};
            default: res = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            F <= 8'h00;
        else
            F <= res;
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Bench for alu_8bit: directed vector table, reset sequence, and a randomized
// pipelined stream checked against an integer-arithmetic reference model.
module tb_alu_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] instruction;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] F;

    int n_checks = 0;
    int n_fail   = 0;

    alu_8bit dut (
        .clk(clk),
        .rst(rst),
        .instruction(instruction),
        .A(A),
        .B(B),
        .F(F)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic int pow2(input int s);
        return 1 << s;
    endfunction

    // Reference model in plain integer arithmetic on values 0..255.
    function automatic logic [7:0] model(input int op, input int a, input int b);
        int s, sa, sb, r;
        s  = b % 8;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0:  r = (a + b) % 256;
            1:  r = (a - b + 256) % 256;
            2:  r = (a * b) % 256;
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = 255 - a;
            7:  r = 255 - (a ^ b);
            8:  r = (a * pow2(s)) % 256;
            9:  r = a / pow2(s);
            10: r = (a / pow2(s)) + ((a >= 128) ? (256 - 256 / pow2(s)) : 0);
            11: r = (a * pow2(s)) % 256 + a / pow2(8 - s);
            12: r = a / pow2(s) + (a * pow2(8 - s)) % 256;
            13: r = (a < b) ? 1 : 0;
            14: r = (a == b) ? 1 : 0;
            default: r = (sa < sb) ? 1 : 0;
        endcase
        return 8'(r);
    endfunction

    vec_t vecs[$];

    initial begin
        logic [7:0] exp_prev;
        logic [3:0] op_r;
        logic [7:0] a_r, b_r;

        vecs.push_back('{"add_wrap", 4'h0, 8'hF0, 8'h20, 8'h10});
        vecs.push_back('{"sub_wrap", 4'h1, 8'h05, 8'h0A, 8'hFB});
        vecs.push_back('{"mul_low",  4'h2, 8'h10, 8'h11, 8'h10});
        vecs.push_back('{"sll",      4'h8, 8'h81, 8'h03, 8'h08});
        vecs.push_back('{"srl_hib",  4'h9, 8'h81, 8'hF9, 8'h40});
        vecs.push_back('{"sra",      4'hA, 8'h81, 8'h01, 8'hC0});
        vecs.push_back('{"rol",      4'hB, 8'h81, 8'h01, 8'h03});
        vecs.push_back('{"ror",      4'hC, 8'h81, 8'h01, 8'hC0});
        vecs.push_back('{"rol_zero", 4'hB, 8'h81, 8'hF8, 8'h81});
        vecs.push_back('{"sra_zero", 4'hA, 8'h81, 8'h08, 8'h81});
        vecs.push_back('{"ltu",      4'hD, 8'h80, 8'h7F, 8'h00});
        vecs.push_back('{"lts",      4'hF, 8'h80, 8'h7F, 8'h01});
        vecs.push_back('{"eq_same",  4'hE, 8'h3C, 8'h3C, 8'h01});
        vecs.push_back('{"eq_diff",  4'hE, 8'h3C, 8'h3D, 8'h00});
        vecs.push_back('{"and",      4'h3, 8'hCC, 8'hAA, 8'h88});
        vecs.push_back('{"or",       4'h4, 8'hCC, 8'hAA, 8'hEE});
        vecs.push_back('{"xor",      4'h5, 8'hCC, 8'hAA, 8'h66});
        vecs.push_back('{"xnor",     4'h7, 8'hCC, 8'hAA, 8'h99});
        vecs.push_back('{"not",      4'h6, 8'hCC, 8'h5A, 8'h33});

        // Reset held two cycles with an ADD pending, then released.
        @(negedge clk);
        rst = 1'b1; instruction = 4'h0; A = 8'hFF; B = 8'hFF;
        @(negedge clk);
        check("reset_cyc1", F, 8'h00);
        @(negedge clk);
        check("reset_cyc2", F, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release", F, 8'hFE);

        foreach (vecs[i]) begin
            instruction = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            @(negedge clk);
            check(vecs[i].name, F, vecs[i].exp);
        end

        // Pipelined random stream: new vector every cycle, checked one cycle later.
        op_r = 4'($urandom); a_r = 8'($urandom); b_r = 8'($urandom);
        instruction = op_r; A = a_r; B = b_r;
        exp_prev = model(int'(op_r), int'(a_r), int'(b_r));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check($sformatf("rand_%0d", i), F, exp_prev);
            rst = (i == 100 || i == 101);
            op_r = 4'($urandom); a_r = 8'($urandom); b_r = 8'($urandom);
            instruction = op_r; A = a_r; B = b_r;
            exp_prev = rst ? 8'h00 : model(int'(op_r), int'(a_r), int'(b_r));
        end
        @(negedge clk);
        check("rand_last", F, exp_prev);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
